mlp_infer_sequencer: RTL and testbench
======================================

# mlp_infer_sequencer

Sequential front-end for the generic 4-input / 3-hidden / 3-output printed MLP datapath, whose weights and intercepts arrive as ports rather than constants. It loads the 168-bit weight vector and 84-bit bias vector from an 8-bit configuration stream and holds them stable. It then feeds one 16-bit sample at a time into the combinational datapath, waits a programmable settle time, and returns the 2-bit argmax class over a valid/ready handshake.

## Interface
- SETTLE_CYCLES, 4, clock cycles allowed for the combinational datapath to settle; legal range 1..255.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_valid  in  1  configuration byte valid.
- cfg_ready  out  1  configuration byte accepted when high with cfg_valid.
- cfg_data  in  8  configuration byte.
- cfg_clear  in  1  single-cycle pulse; discards the loaded configuration.
- cfg_done  out  1  complete, valid configuration held.
- cfg_err  out  1  last load failed its checksum; only driven when the checksum is compiled in, otherwise tied 0.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when high with in_valid.
- in_data  in  16  four 4-bit features, feature 0 in bits [3:0].
- out_valid  out  1  class result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  2  argmax class, values 0..2.
- dp_inp  out  16  registered sample driven to the datapath.
- dp_weights  out  168  registered weight vector driven to the datapath.
- dp_biases  out  84  registered bias vector driven to the datapath.
- dp_out  in  2  datapath class output.

## Operation
- Parameter image P[255:0] = {4'b0, dp_biases, dp_weights}. Configuration byte k, for k = 0..31, writes P[8k+7:8k]. The upper nibble of byte 31 is discarded.
- States and transitions:
  - UNCFG → LOAD on the first accepted byte.
  - LOAD → IDLE after the final byte.
  - IDLE → LOAD on an accepted byte, which starts a reload and clears cfg_done.
  - IDLE → EVAL on a sample handshake.
  - EVAL → DONE when the settle counter expires.
  - DONE → IDLE on an out handshake.
- cfg_ready = 1 in UNCFG, LOAD and IDLE; 0 in EVAL and DONE.
- in_ready = 1 only in IDLE with cfg_done = 1.
- Byte counter: 6 bits. It resets to 0 on rst, on cfg_clear, and on entry to LOAD from UNCFG or IDLE. It increments per accepted byte.
- dp_weights and dp_biases change only on accepted bytes. They are never modified in EVAL or DONE.
- Sample handshake: dp_inp <= in_data, and the settle counter loads SETTLE_CYCLES-1.
- EVAL: the counter decrements each cycle. At count 0, out_class <= dp_out, out_valid <= 1, and the state moves to DONE.
- DONE: out_valid and out_class hold until out_ready. One sample is in flight at a time; there is no overlap.
- cfg_clear, in any state: go to UNCFG, cfg_done <= 0, out_valid <= 0, byte counter <= 0. Parameter registers keep their contents.
- cfg_clear together with cfg_valid: the clear wins and the byte is dropped.
- Reset values: cfg_done 0, cfg_err 0, out_valid 0, out_class 0, in_ready 0, cfg_ready 1, and dp_inp, dp_weights, dp_biases all zero. rst mid-load or mid-eval aborts to UNCFG.

## Timing
- Configuration: one byte per cycle at full rate.
  - Without checksum, cfg_done rises in the cycle after byte 31 is accepted.
- Inference latency: a sample accepted at edge E0 gives out_valid high after edge E0+SETTLE_CYCLES.
  - SETTLE_CYCLES = 1: out_valid is high in the cycle immediately after acceptance.
- Throughput: one result per SETTLE_CYCLES+2 cycles when out_ready is held at 1. The cycles are the accept edge, SETTLE_CYCLES settle cycles, and one DONE cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- MLP_CFG_CHECKSUM_EN defined:
  - The load is 33 bytes. Byte 32 is a checksum.
  - The load passes when the 8-bit sum of bytes 0..32 equals 0. Then cfg_done <= 1, cfg_err <= 0, and the state goes to IDLE.
  - On mismatch: cfg_err <= 1, cfg_done <= 0, and the state goes to UNCFG.
  - cfg_err clears when the next load's first byte is accepted.
- MLP_CFG_CHECKSUM_EN undefined:
  - The load is 32 bytes, with no checksum byte.
  - cfg_err is tied 0.

## Test plan
- Reset check: after rst, cfg_ready = 1, in_ready = 0, out_valid = 0, and dp_weights = dp_biases = 0. A sample presented while unconfigured is not accepted.
- Bias-only load: bytes 0..31 all 8'h00 except byte 29 = 8'h50, which sets biases[83:68] = 5. Then in_data = 16'h1234 with SETTLE_CYCLES = 4 gives out_valid exactly 4 cycles after acceptance, with out_class = 2.
- Checksum (macro defined): the load above followed by byte 32 = 8'hB0 gives cfg_done = 1. Reloading with byte 32 = 8'hB1 gives cfg_err = 1, cfg_done = 0, and in_ready staying 0.
- Backpressure: hold out_ready = 0 for 10 cycles. out_valid and out_class must stay stable. cfg_valid = 1 during that window gets cfg_ready = 0, and dp_weights is unchanged.
- cfg_clear during EVAL: out_valid never rises and the state returns to UNCFG. A following 32-byte (or 33-byte) reload restores cfg_done = 1.
- cfg_clear and cfg_valid in the same cycle: the byte is dropped, and the byte counter and state are as after a plain cfg_clear.

Source files
------------

// File: rtl/mlp_infer_sequencer.sv
// mlp_infer_sequencer: loads MLP weights/biases from a byte stream, then sequences one sample at a time through the external datapath.
// Define MLP_CFG_CHECKSUM_EN to append an 8-bit checksum byte (byte 32) to each configuration load.
module mlp_infer_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [7:0]   cfg_data,
  input  logic         cfg_clear,
  output logic         cfg_done,
  output logic         cfg_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_class,
  output logic [15:0]  dp_inp,
  output logic [167:0] dp_weights,
  output logic [83:0]  dp_biases,
  input  logic [1:0]   dp_out
);
  typedef enum logic [2:0] {UNCFG, LOAD, IDLE, EVAL, DONE} state_t;
`ifdef MLP_CFG_CHECKSUM_EN
  localparam logic [5:0] LAST = 6'd32;
`else
  localparam logic [5:0] LAST = 6'd31;
`endif
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, idx;
  logic [7:0] settle_q, settle_d;
  logic [251:0] p_q, p_d;
  logic [15:0] inp_q, inp_d;
  logic done_q, done_d, ov_q, ov_d;
  logic [1:0] cls_q, cls_d;
  logic first, cfg_acc, in_acc;
`ifdef MLP_CFG_CHECKSUM_EN
  logic err_q, err_d;
  logic [7:0] sum_q, sum_d;
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif
  assign cfg_ready  = state_q inside {UNCFG, LOAD, IDLE};
  assign in_ready   = (state_q == IDLE) && done_q;
  assign cfg_done   = done_q;
  assign out_valid  = ov_q;
  assign out_class  = cls_q;
  assign dp_inp     = inp_q;
  assign dp_weights = p_q[167:0];
  assign dp_biases  = p_q[251:168];
  // The byte accepted outside LOAD is always byte 0 of a fresh load
  assign first   = state_q != LOAD;
  assign idx     = first ? 6'd0 : cnt_q;
  assign cfg_acc = cfg_valid && cfg_ready && !cfg_clear;
  assign in_acc  = in_valid && in_ready;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    p_d      = p_q;
    inp_d    = inp_q;
    done_d   = done_q;
    ov_d     = ov_q;
    cls_d    = cls_q;
`ifdef MLP_CFG_CHECKSUM_EN
    err_d    = err_q;
    sum_d    = sum_q;
`endif
    if (cfg_clear) begin
      state_d = UNCFG;
      done_d  = 1'b0;
      ov_d    = 1'b0;
      cnt_d   = 6'd0;
    end else if (cfg_acc) begin
      // A configuration byte in IDLE takes priority and starts a reload
      state_d = LOAD;
      done_d  = 1'b0;
      cnt_d   = idx + 6'd1;
      if (idx < 6'd31) p_d[{idx[4:0], 3'b000} +: 8] = cfg_data;
      else if (idx == 6'd31) p_d[251:248] = cfg_data[3:0];
`ifdef MLP_CFG_CHECKSUM_EN
      err_d = first ? 1'b0 : err_q;
      sum_d = (first ? 8'd0 : sum_q) + cfg_data;
      if (idx == LAST) begin
        state_d = (sum_d == 8'd0) ? IDLE : UNCFG;
        done_d  = sum_d == 8'd0;
        err_d   = sum_d != 8'd0;
      end
`else
      if (idx == LAST) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
    end else if (in_acc) begin
      state_d  = EVAL;
      inp_d    = in_data;
      settle_d = 8'(SETTLE_CYCLES - 1);
    end else if (state_q == EVAL) begin
      settle_d = (settle_q == 8'd0) ? settle_q : settle_q - 8'd1;
      state_d  = (settle_q == 8'd0) ? DONE : EVAL;
      ov_d     = settle_q == 8'd0;
      cls_d    = (settle_q == 8'd0) ? dp_out : cls_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      ov_d    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNCFG;
      cnt_q    <= '0;
      settle_q <= '0;
      p_q      <= '0;
      inp_q    <= '0;
      done_q   <= 1'b0;
      ov_q     <= 1'b0;
      cls_q    <= '0;
`ifdef MLP_CFG_CHECKSUM_EN
      err_q    <= 1'b0;
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      p_q      <= p_d;
      inp_q    <= inp_d;
      done_q   <= done_d;
      ov_q     <= ov_d;
      cls_q    <= cls_d;
`ifdef MLP_CFG_CHECKSUM_EN
      err_q    <= err_d;
      sum_q    <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_mlp_infer_sequencer.sv
// tb_mlp_infer_sequencer: directed + random checks of mlp_infer_sequencer against a byte-image reference model and a stand-in datapath.
module tb_mlp_infer_sequencer;
  localparam int S = 4;
`ifdef MLP_CFG_CHECKSUM_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif
  logic clk = 0, rst = 1, cfg_valid = 0, cfg_clear = 0, in_valid = 0, out_ready = 0;
  logic [7:0] cfg_data = 0;
  logic [15:0] in_data = 0;
  logic cfg_ready, cfg_done, cfg_err, in_ready, out_valid;
  logic [1:0] out_class, dp_out;
  logic [15:0] dp_inp;
  logic [167:0] dp_weights;
  logic [83:0] dp_biases;
  int vectors = 0, miscompares = 0;
  logic [7:0] nb [32];
  logic [7:0] mp [32];

  mlp_infer_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_clear(cfg_clear), .cfg_done(cfg_done), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .dp_inp(dp_inp), .dp_weights(dp_weights), .dp_biases(dp_biases),
    .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] cls_f(input logic [15:0] b, input logic [7:0] w0, input logic [7:0] w1, input logic [15:0] x);
    return 2'((32'(b) + 32'(w0) * 32'(x[3:0]) + 32'(w1) * 32'(x[7:4])) % 32'd3);
  endfunction

  // Stand-in for the combinational MLP datapath
  assign dp_out = cls_f(dp_biases[83:68], dp_weights[7:0], dp_weights[15:8], dp_inp);

  function automatic logic [251:0] img();
    logic [251:0] r = '0;
    for (int k = 0; k < 31; k++) r[k*8 +: 8] = mp[k];
    r[251:248] = mp[31][3:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int n, input logic [7:0] cs_adj);
    logic [7:0] s = 8'd0;
    for (int k = 0; k < 32; k++) s = s + nb[k];
    for (int k = 0; k < n; k++) begin
      cfg_valid = 1;
      cfg_data = (k < 32) ? nb[k] : 8'd0 - s + cs_adj;
      tick();
      if (k < 32) mp[k] = nb[k];
    end
    cfg_valid = 0;
  endtask

  task automatic chk_image(input string tag);
    logic [251:0] e = img();
    chk({tag, "_weights"}, 256'(dp_weights), 256'(e[167:0]));
    chk({tag, "_biases"}, 256'(dp_biases), 256'(e[251:168]));
  endtask

  task automatic run_sample(input logic [15:0] x);
    int n = 0;
    logic [251:0] e = img();
    in_valid = 1;
    in_data = x;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_wait", 256'(in_ready), 256'(1));
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("latency", 256'(n), 256'(S));
    chk("out_class", 256'(out_class), 256'(cls_f(e[251:236], e[7:0], e[15:8], x)));
    chk("dp_inp", 256'(dp_inp), 256'(x));
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("out_valid_drop", 256'(out_valid), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] c;
    logic [167:0] w;
    logic [15:0] x;
    int n;
    for (int k = 0; k < 32; k++) begin nb[k] = 0; mp[k] = 0; end
    tick(); tick();
    rst = 0;
    chk("rst_cfg_ready", 256'(cfg_ready), 256'(1));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_class", 256'(out_class), 256'(0));
    chk("rst_cfg_done", 256'(cfg_done), 256'(0));
    chk("rst_cfg_err", 256'(cfg_err), 256'(0));
    chk("rst_dp_inp", 256'(dp_inp), 256'(0));
    chk_image("rst");
    in_valid = 1;
    in_data = 16'hBEEF;
    tick(); tick(); tick();
    chk("uncfg_in_ready", 256'(in_ready), 256'(0));
    chk("uncfg_dp_inp", 256'(dp_inp), 256'(0));
    in_valid = 0;
    nb[29] = 8'h50;
    send(NB, 8'd0);
    chk("bias_cfg_done", 256'(cfg_done), 256'(1));
    chk("bias_cfg_err", 256'(cfg_err), 256'(0));
    chk("bias_field", 256'(dp_biases[83:68]), 256'(5));
    chk_image("bias");
    run_sample(16'h1234);
    chk("bias_class2", 256'(out_class), 256'(2));
`ifdef MLP_CFG_CHECKSUM_EN
    send(NB, 8'd1);
    chk("bad_cs_err", 256'(cfg_err), 256'(1));
    chk("bad_cs_done", 256'(cfg_done), 256'(0));
    chk("bad_cs_cfg_ready", 256'(cfg_ready), 256'(1));
    in_valid = 1;
    tick(); tick(); tick();
    chk("bad_cs_in_ready", 256'(in_ready), 256'(0));
    in_valid = 0;
    send(NB, 8'd0);
    chk("good_cs_err", 256'(cfg_err), 256'(0));
    chk("good_cs_done", 256'(cfg_done), 256'(1));
`endif
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 32; k++) nb[k] = 8'($urandom);
      send(NB, 8'd0);
      chk("rnd_cfg_done", 256'(cfg_done), 256'(1));
      chk_image("rnd");
      for (int j = 0; j < 4; j++) run_sample(16'($urandom));
    end
    x = 16'($urandom);
    in_valid = 1;
    in_data = x;
    chk("bp_in_ready", 256'(in_ready), 256'(1));
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("bp_latency", 256'(n), 256'(S));
    c = out_class;
    w = dp_weights;
    chk("bp_class", 256'(c), 256'(cls_f(img()[251:236], img()[7:0], img()[15:8], x)));
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1;
      cfg_data = 8'($urandom);
      chk("bp_cfg_ready", 256'(cfg_ready), 256'(0));
      tick();
      chk("bp_out_valid", 256'(out_valid), 256'(1));
      chk("bp_out_class", 256'(out_class), 256'(c));
      chk("bp_weights", 256'(dp_weights), 256'(w));
    end
    cfg_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("bp_release", 256'(out_valid), 256'(0));
    in_valid = 1;
    in_data = 16'($urandom);
    tick();
    in_valid = 0;
    tick();
    cfg_clear = 1;
    tick();
    cfg_clear = 0;
    chk("clr_cfg_done", 256'(cfg_done), 256'(0));
    chk("clr_cfg_ready", 256'(cfg_ready), 256'(1));
    chk("clr_in_ready", 256'(in_ready), 256'(0));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("clr_out_valid", 256'(out_valid), 256'(0));
    end
    chk_image("clr_keep");
    for (int k = 0; k < 32; k++) nb[k] = 8'($urandom);
    send(NB, 8'd0);
    chk("reload_cfg_done", 256'(cfg_done), 256'(1));
    chk_image("reload");
    run_sample(16'($urandom));
    for (int k = 0; k < 32; k++) nb[k] = 8'($urandom);
    send(10, 8'd0);
    cfg_clear = 1;
    cfg_valid = 1;
    cfg_data = ~mp[10];
    tick();
    cfg_clear = 0;
    cfg_valid = 0;
    chk("clrv_cfg_done", 256'(cfg_done), 256'(0));
    chk("clrv_cfg_ready", 256'(cfg_ready), 256'(1));
    chk("clrv_in_ready", 256'(in_ready), 256'(0));
    chk_image("clrv_drop");
    for (int k = 0; k < 32; k++) nb[k] = 8'($urandom);
    send(NB, 8'd0);
    chk("clrv_reload_done", 256'(cfg_done), 256'(1));
    chk_image("clrv_reload");
    run_sample(16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
